pipeline_hazard_scoreboard: RTL and testbench

Parametrised hazard/forwarding controller for the in-order RISC-V pipeline, replacing the fixed combinational hazard logic with a registered scoreboard. It tracks every instruction from execute to writeback in an internal shadow pipeline of depth FWD_DEPTH. From that state it generates fetch/decode stalls, decode/execute flushes and N-way forward selects, and it freezes cleanly on an external memory stall. Sits beside the fetch/decode/execute/memory/writeback stages at core top level.

---
 rtl/pipeline_hazard_scoreboard.sv | 201 ++++++++++++++++++++
 tb/tb_pipeline_hazard_scoreboard.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_scoreboard
// Description : Registered hazard/forwarding scoreboard for the in-order
//               RISC-V pipeline. A shadow pipeline (stage 0 = E, stages
//               1..FWD_DEPTH = M..W) records {valid, rd, we, load} for every
//               instruction past decode, and the stall/flush/forward controls
//               are derived from it. The whole scoreboard holds while
//               mem_stall is high.
// Ports       : clk, srst_n (async, active-low)
//               valid_d, rs1_d, rs2_d, rd_d, reg_write_d, is_load_d - decode
//               pcsrc_e   - taken branch/jump resolved in execute
//               mem_stall - data memory not ready, pipeline freezes
//               stall_f, stall_d, flush_d, flush_e, freeze - pipeline control
//               forward_a_e, forward_b_e - 0 = regfile, k = stage k result
//               stall_cnt, flush_cnt, fwd_cnt - performance counters
// Options     : HAZARD_PERF_CNT_EN - when defined, builds saturating
//               performance counters; otherwise the counter ports are 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_scoreboard #(
    parameter int NUM_REGS         = 32,
    parameter int FWD_DEPTH        = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int CNT_W            = 32,
    localparam int REG_AW          = $clog2(NUM_REGS),
    localparam int FWD_W           = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              reg_write_d,
    input  logic              is_load_d,
    input  logic              pcsrc_e,
    input  logic              mem_stall,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              freeze,
    output logic [FWD_W-1:0]  forward_a_e,
    output logic [FWD_W-1:0]  forward_b_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  fwd_cnt
);

    // Shadow pipeline state, index 0 = E stage
    logic              r_valid [0:FWD_DEPTH];
    logic [REG_AW-1:0] r_rd    [0:FWD_DEPTH];
    logic              r_we    [0:FWD_DEPTH];
    logic              r_load  [0:FWD_DEPTH];
    logic [REG_AW-1:0] r_rs1_e;
    logic [REG_AW-1:0] r_rs2_e;

    logic [FWD_DEPTH:0] w_prod;     // stage k will write a nonzero register
    logic [FWD_DEPTH:0] w_match_d;  // stage k produces rs1_d or rs2_d
    logic [FWD_DEPTH:1] w_match_a;
    logic [FWD_DEPTH:1] w_match_b;
    logic [FWD_W-1:0]   w_fwd_a;
    logic [FWD_W-1:0]   w_fwd_b;
    logic               w_lu_hit;
    logic               w_lu;
    logic               w_flush_d;
    logic               w_flush_e;
    logic               w_take;

    // Excluding rd == 0 here is enough to keep x0 from ever matching, since
    // a match additionally requires equality with the source register.
    always_comb begin
        w_prod    = '0;
        w_match_d = '0;
        for (int k = 0; k <= FWD_DEPTH; k++) begin
            w_prod[k]    = r_valid[k] & r_we[k] & (r_rd[k] != '0);
            w_match_d[k] = w_prod[k] & ((r_rd[k] == rs1_d) | (r_rd[k] == rs2_d));
        end
    end

    always_comb begin
        w_match_a = '0;
        w_match_b = '0;
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            w_match_a[k] = w_prod[k] & (r_rd[k] == r_rs1_e);
            w_match_b[k] = w_prod[k] & (r_rd[k] == r_rs2_e);
        end
    end

    // Walk from the oldest stage to the youngest so the youngest eligible
    // producer is the last one written and therefore wins.
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (w_match_a[k] && (!r_load[k] || k >= LOAD_READY_STAGE)) begin
                w_fwd_a = FWD_W'(k);
            end
            if (w_match_b[k] && (!r_load[k] || k >= LOAD_READY_STAGE)) begin
                w_fwd_b = FWD_W'(k);
            end
        end
    end

    // A load in stage j reaches a forwardable stage one cycle after the
    // consumer would enter E, so the consumer must wait in decode.
    always_comb begin
        w_lu_hit = 1'b0;
        for (int j = 0; j <= FWD_DEPTH; j++) begin
            if ((j + 1 < LOAD_READY_STAGE) && w_match_d[j] && r_load[j]) begin
                w_lu_hit = 1'b1;
            end
        end
    end

    assign w_lu      = valid_d & w_lu_hit;
    assign w_flush_d = pcsrc_e & ~mem_stall;
    assign w_flush_e = (w_lu | pcsrc_e) & ~mem_stall;
    assign w_take    = valid_d & ~w_flush_e;

    assign stall_f     = (w_lu & ~pcsrc_e) | mem_stall;
    assign stall_d     = (w_lu & ~pcsrc_e) | mem_stall;
    assign flush_d     = w_flush_d;
    assign flush_e     = w_flush_e;
    assign freeze      = mem_stall;
    assign forward_a_e = w_fwd_a;
    assign forward_b_e = w_fwd_b;

    // Bubbles clear the E-stage sources so an empty E never selects a
    // forward path.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            for (int k = 0; k <= FWD_DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_rd[k]    <= '0;
                r_we[k]    <= 1'b0;
                r_load[k]  <= 1'b0;
            end
            r_rs1_e <= '0;
            r_rs2_e <= '0;
        end else if (!mem_stall) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_rd[k]    <= r_rd[k-1];
                r_we[k]    <= r_we[k-1];
                r_load[k]  <= r_load[k-1];
            end
            if (w_take) begin
                r_valid[0] <= 1'b1;
                r_rd[0]    <= rd_d;
                r_we[0]    <= reg_write_d;
                r_load[0]  <= is_load_d;
                r_rs1_e    <= rs1_d;
                r_rs2_e    <= rs2_d;
            end else begin
                r_valid[0] <= 1'b0;
                r_rd[0]    <= '0;
                r_we[0]    <= 1'b0;
                r_load[0]  <= 1'b0;
                r_rs1_e    <= '0;
                r_rs2_e    <= '0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;

    // Counters saturate at all-ones.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_lu && !pcsrc_e && !mem_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_d && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (!mem_stall && ((w_fwd_a != '0) || (w_fwd_b != '0)) && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_scoreboard
// Description : Self-checking bench for pipeline_hazard_scoreboard. Two
//               instances share stimulus: default parameters, and
//               FWD_DEPTH = 4 / LOAD_READY_STAGE = 3. Expected outputs are
//               queued as each cycle's stimulus is applied and popped when
//               the outputs are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_scoreboard;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit c_cnt_en = 1'b1;
`else
    localparam bit c_cnt_en = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       srst_n = 1'b0;
    logic       valid_d = 1'b0;
    logic [4:0] rs1_d = '0;
    logic [4:0] rs2_d = '0;
    logic [4:0] rd_d = '0;
    logic       reg_write_d = 1'b0;
    logic       is_load_d = 1'b0;
    logic       pcsrc_e = 1'b0;
    logic       mem_stall = 1'b0;

    logic        stall_f2, stall_d2, flush_d2, flush_e2, freeze2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [31:0] stall_cnt2, flush_cnt2, fwd_cnt2;
    logic        stall_f4, stall_d4, flush_d4, flush_e4, freeze4;
    logic [2:0]  fwd_a4, fwd_b4;
    logic [31:0] stall_cnt4, flush_cnt4, fwd_cnt4;

    pipeline_hazard_scoreboard u_dut2 (
        .clk(clk), .srst_n(srst_n), .valid_d(valid_d), .rs1_d(rs1_d),
        .rs2_d(rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d),
        .is_load_d(is_load_d), .pcsrc_e(pcsrc_e), .mem_stall(mem_stall),
        .stall_f(stall_f2), .stall_d(stall_d2), .flush_d(flush_d2),
        .flush_e(flush_e2), .freeze(freeze2), .forward_a_e(fwd_a2),
        .forward_b_e(fwd_b2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2),
        .fwd_cnt(fwd_cnt2)
    );

    pipeline_hazard_scoreboard #(.FWD_DEPTH(4), .LOAD_READY_STAGE(3)) u_dut4 (
        .clk(clk), .srst_n(srst_n), .valid_d(valid_d), .rs1_d(rs1_d),
        .rs2_d(rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d),
        .is_load_d(is_load_d), .pcsrc_e(pcsrc_e), .mem_stall(mem_stall),
        .stall_f(stall_f4), .stall_d(stall_d4), .flush_d(flush_d4),
        .flush_e(flush_e4), .freeze(freeze4), .forward_a_e(fwd_a4),
        .forward_b_e(fwd_b4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4),
        .fwd_cnt(fwd_cnt4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       we, ld, pc, ms;
    } stim_t;

    typedef struct packed {
        logic       sf, sd, fd, fe, fz;
        logic [2:0] fa, fb;
    } obs_t;

    obs_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic stim_t ins(input int rs1, input int rs2, input int rd,
                                  input bit we, input bit ld);
        stim_t s;
        s     = '0;
        s.v   = 1'b1;
        s.rs1 = 5'(rs1);
        s.rs2 = 5'(rs2);
        s.rd  = 5'(rd);
        s.we  = we;
        s.ld  = ld;
        return s;
    endfunction

    function automatic stim_t ctl(input stim_t base, input bit pc, input bit ms);
        stim_t s;
        s    = base;
        s.pc = pc;
        s.ms = ms;
        return s;
    endfunction

    function automatic obs_t ex(input bit sf, input bit fd, input bit fe,
                                input bit fz, input int fa, input int fb);
        obs_t o;
        o.sf = sf;
        o.sd = sf;
        o.fd = fd;
        o.fe = fe;
        o.fz = fz;
        o.fa = 3'(fa);
        o.fb = 3'(fb);
        return o;
    endfunction

    function automatic obs_t obs2();
        return {stall_f2, stall_d2, flush_d2, flush_e2, freeze2, 1'b0, fwd_a2, 1'b0, fwd_b2};
    endfunction

    function automatic obs_t obs4();
        return {stall_f4, stall_d4, flush_d4, flush_e4, freeze4, fwd_a4, fwd_b4};
    endfunction

    task automatic apply(input stim_t s);
        valid_d     = s.v;
        rs1_d       = s.rs1;
        rs2_d       = s.rs2;
        rd_d        = s.rd;
        reg_write_d = s.we;
        is_load_d   = s.ld;
        pcsrc_e     = s.pc;
        mem_stall   = s.ms;
    endtask

    task automatic do_reset();
        apply('0);
        srst_n = 1'b0;
        #2;
        srst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        apply('0);
        srst_n = 1'b0;
        #1;
        got = obs2();
        n_cmp++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_out2: got %h expected %h", got, 11'h0);
        end
        got = obs4();
        n_cmp++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_out4: got %h expected %h", got, 11'h0);
        end
        n_cmp++;
        if ({stall_cnt2, flush_cnt2, fwd_cnt2} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h %h %h expected 0 0 0", stall_cnt2, flush_cnt2, fwd_cnt2);
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        obs_t  e[$];
        obs_t  got, want;
        do_reset();
        st.push_back(ins(1, 2, 5, 1, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(5, 1, 6, 1, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back('0);                 e.push_back(ex(0, 0, 0, 0, 1, 0));
        st.push_back('0);                 e.push_back(ex(0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = obs2();
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        obs_t  e[$];
        obs_t  got, want;
        do_reset();
        st.push_back(ins(1, 0, 5, 1, 1)); e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(5, 5, 6, 1, 0)); e.push_back(ex(1, 0, 1, 0, 0, 0));
        st.push_back(ins(5, 5, 6, 1, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back('0);                 e.push_back(ex(0, 0, 0, 0, 2, 2));
        foreach (st[i]) begin
            apply(st[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = obs2();
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL load_use step %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (stall_cnt2 !== 32'(c_cnt_en)) begin
            n_fail++;
            $display("FAIL load_use_stall_cnt: got %0d expected %0d", stall_cnt2, 32'(c_cnt_en));
        end
        n_cmp++;
        if (fwd_cnt2 !== 32'(c_cnt_en)) begin
            n_fail++;
            $display("FAIL load_use_fwd_cnt: got %0d expected %0d", fwd_cnt2, 32'(c_cnt_en));
        end
    endtask

    task automatic test_youngest_x0();
        stim_t st[$];
        obs_t  e[$];
        obs_t  got, want;
        do_reset();
        st.push_back(ins(1, 2, 5, 1, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(3, 0, 5, 1, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(5, 0, 8, 1, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back('0);                 e.push_back(ex(0, 0, 0, 0, 1, 0));
        st.push_back(ins(1, 2, 0, 1, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(0, 0, 9, 1, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back('0);                 e.push_back(ex(0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = obs2();
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL youngest_x0 step %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch_load_use();
        stim_t st[$];
        obs_t  e[$];
        obs_t  got, want;
        do_reset();
        st.push_back(ins(1, 0, 5, 1, 1));              e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ctl(ins(5, 1, 6, 1, 0), 1, 0));   e.push_back(ex(0, 1, 1, 0, 0, 0));
        st.push_back('0);                              e.push_back(ex(0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = obs2();
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL branch_lu step %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({flush_cnt2, stall_cnt2} !== {32'(c_cnt_en), 32'h0}) begin
            n_fail++;
            $display("FAIL branch_lu_cnt: got flush %0d stall %0d expected flush %0d stall 0",
                     flush_cnt2, stall_cnt2, 32'(c_cnt_en));
        end
    endtask

    task automatic test_mem_stall();
        stim_t st[$];
        obs_t  e[$];
        obs_t  got, want;
        do_reset();
        st.push_back(ins(1, 2, 5, 1, 0));              e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(5, 1, 6, 1, 0));              e.push_back(ex(0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            st.push_back(ctl(ins(3, 4, 7, 1, 0), 1, 1)); e.push_back(ex(1, 0, 0, 1, 1, 0));
        end
        st.push_back(ctl(ins(3, 4, 7, 1, 0), 1, 0));   e.push_back(ex(0, 1, 1, 0, 1, 0));
        st.push_back('0);                              e.push_back(ex(0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = obs2();
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL mem_stall step %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({flush_cnt2, fwd_cnt2} !== {32'(c_cnt_en), 32'(c_cnt_en)}) begin
            n_fail++;
            $display("FAIL mem_stall_cnt: got flush %0d fwd %0d expected %0d %0d",
                     flush_cnt2, fwd_cnt2, 32'(c_cnt_en), 32'(c_cnt_en));
        end
    endtask

    task automatic test_depth4();
        stim_t st[$];
        obs_t  e[$];
        obs_t  got, want;
        do_reset();
        st.push_back(ins(1, 0, 7, 1, 1)); e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(7, 2, 8, 1, 0)); e.push_back(ex(1, 0, 1, 0, 0, 0));
        st.push_back(ins(7, 2, 8, 1, 0)); e.push_back(ex(1, 0, 1, 0, 0, 0));
        st.push_back(ins(7, 2, 8, 1, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back('0);                 e.push_back(ex(0, 0, 0, 0, 3, 0));
        st.push_back(ins(1, 0, 7, 1, 1)); e.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(7, 2, 8, 1, 0)); e.push_back(ex(1, 0, 1, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = obs4();
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL depth4 step %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        // Load now in stage 1: still inside the load-use window.
        #1;
        got  = obs4();
        want = ex(1, 0, 1, 0, 0, 0);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL depth4_second_stall: got %h expected %h", got, want);
        end
        srst_n = 1'b0;
        #1;
        got = obs4();
        n_cmp++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL depth4_async_reset: got %h expected %h", got, 11'h0);
        end
        n_cmp++;
        if ({stall_cnt4, flush_cnt4, fwd_cnt4} !== 96'h0) begin
            n_fail++;
            $display("FAIL depth4_reset_cnt: got %0d %0d %0d expected 0 0 0",
                     stall_cnt4, flush_cnt4, fwd_cnt4);
        end
        @(negedge clk);
        srst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_youngest_x0();
        test_branch_load_use();
        test_mem_stall();
        test_depth4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
